pll_drp_reconfig: RTL and testbench

- DRP master that reconfigures a PLLE2-style PLL model through its dynamic reconfiguration port (DADDR/DEN/DWE/DI/DO/DRDY).
- Holds the PLL in reset during reconfiguration.
- Applies a streamed list of read-modify-write register updates.
- Releases the PLL and waits for LOCKED before signalling done; sits between a host/sequencer and the PLL instance.

---
 rtl/drp_pkg.sv | 43 ++++
 rtl/drp_txn.sv | 87 ++++++++
 rtl/pll_drp_reconfig.sv | 218 +++++++++++++++++++++
 tb/tb_pll_drp_reconfig.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : drp_pkg
// Description : Shared definitions for the PLL DRP reconfiguration master:
//               DRP bus widths, controller state encoding, the streamed
//               configuration-entry record and the read-modify-write merge.
// Revision    : 1.0 - initial release
// ============================================================================
package drp_pkg;

    localparam int DRP_ADDR_W = 7;
    localparam int DRP_DATA_W = 16;

    // Controller state encoding
    typedef logic [2:0] state_t;
    localparam state_t c_st_idle      = 3'd0;
    localparam state_t c_st_rst_hold  = 3'd1;
    localparam state_t c_st_fetch     = 3'd2;
    localparam state_t c_st_read      = 3'd3;
    localparam state_t c_st_wait_rd   = 3'd4;
    localparam state_t c_st_write     = 3'd5;
    localparam state_t c_st_wait_wr   = 3'd6;
    localparam state_t c_st_wait_lock = 3'd7;

    // One register update taken from the host stream
    typedef struct packed {
        logic [DRP_ADDR_W-1:0] addr;
        logic [DRP_DATA_W-1:0] mask;
        logic [DRP_DATA_W-1:0] data;
        logic                  last;
    } cfg_entry_t;

    // Mask bit 1 keeps the bit read back from the PLL, 0 takes the new bit.
    function automatic logic [DRP_DATA_W-1:0] rmw_merge(
        input logic [DRP_DATA_W-1:0] old_val,
        input logic [DRP_DATA_W-1:0] mask,
        input logic [DRP_DATA_W-1:0] new_val
    );
        return (old_val & mask) | (new_val & ~mask);
    endfunction

endpackage
`default_nettype wire

// File: rtl/drp_txn.sv
`default_nettype none
// ============================================================================
// Module      : drp_txn
// Description : One DRP access: a single-cycle DEN strobe (read or write)
//               followed by a wait for DRDY with timeout. The wait counter is
//               owned by the caller and must read 0 on the first wait cycle.
// Ports       : clk/rst          - clock, synchronous active-high reset
//               i_start/i_we     - launch a read (we=0) or write (we=1)
//               i_addr/i_wdata   - access address and write data
//               i_count          - caller's cycle counter for the wait phase
//               o_den/o_dwe/o_daddr/o_di - DRP strobe side (registered)
//               i_do/i_drdy      - DRP response side
//               o_rd_data/o_ok/o_timeout - completion (valid in the wait cycle)
// Revision    : 1.0 - initial release
// ============================================================================
module drp_txn
    import drp_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int CNT_W        = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_we,
    input  logic [DRP_ADDR_W-1:0] i_addr,
    input  logic [DRP_DATA_W-1:0] i_wdata,
    input  logic [CNT_W-1:0]      i_count,
    output logic                  o_den,
    output logic                  o_dwe,
    output logic [DRP_ADDR_W-1:0] o_daddr,
    output logic [DRP_DATA_W-1:0] o_di,
    input  logic [DRP_DATA_W-1:0] i_do,
    input  logic                  i_drdy,
    output logic [DRP_DATA_W-1:0] o_rd_data,
    output logic                  o_ok,
    output logic                  o_timeout
);

    // The strobe cycle counts toward the timeout budget, so the wait phase
    // itself gets DRDY_TIMEOUT-1 cycles in which DRDY is sampled.
    localparam logic [CNT_W-1:0] c_wait_last = CNT_W'(DRDY_TIMEOUT - 2);

    logic                  r_den;
    logic                  r_dwe;
    logic                  r_pending;
    logic [DRP_ADDR_W-1:0] r_daddr;
    logic [DRP_DATA_W-1:0] r_di;
    logic                  w_waiting;

    // DRDY is only meaningful after the strobe cycle of an outstanding access.
    assign w_waiting = r_pending & ~r_den;
    assign o_ok      = w_waiting & i_drdy;
    assign o_timeout = w_waiting & ~i_drdy & (i_count == c_wait_last);
    assign o_rd_data = i_do;

    assign o_den   = r_den;
    assign o_dwe   = r_dwe;
    assign o_daddr = r_daddr;
    assign o_di    = r_di;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_den     <= 1'b0;
            r_dwe     <= 1'b0;
            r_pending <= 1'b0;
            r_daddr   <= '0;
            r_di      <= '0;
        end else begin
            r_den <= 1'b0;
            r_dwe <= 1'b0;
            if (i_start) begin
                r_den     <= 1'b1;
                r_dwe     <= i_we;
                r_daddr   <= i_addr;
                r_pending <= 1'b1;
                if (i_we) begin
                    r_di <= i_wdata;
                end
            end else if (o_ok || o_timeout) begin
                r_pending <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : pll_drp_reconfig
// Description : DRP master that holds a PLL in reset, applies a streamed list
//               of read-modify-write register updates, releases the PLL and
//               waits for LOCKED before pulsing done.
// Ports       : DCLK/RST              - clock, synchronous active-high reset
//               start/busy/done/error - host control and status
//               cfg_*                 - configuration entry stream (valid/ready)
//               DADDR/DEN/DWE/DI/DO/DRDY - dynamic reconfiguration port
//               PLL_RST/LOCKED        - PLL reset and lock indication
// Revision    : 1.0 - initial release
// ============================================================================
module pll_drp_reconfig
    import drp_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 4,
    parameter int DRDY_TIMEOUT    = 64,
    parameter int LOCK_TIMEOUT    = 65535
) (
    input  logic                  DCLK,
    input  logic                  RST,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [DRP_ADDR_W-1:0] cfg_addr,
    input  logic [DRP_DATA_W-1:0] cfg_mask,
    input  logic [DRP_DATA_W-1:0] cfg_data,
    input  logic                  cfg_last,
    output logic [DRP_ADDR_W-1:0] DADDR,
    output logic                  DEN,
    output logic                  DWE,
    output logic [DRP_DATA_W-1:0] DI,
    input  logic [DRP_DATA_W-1:0] DO,
    input  logic                  DRDY,
    output logic                  PLL_RST,
    input  logic                  LOCKED
);

    // One counter serves reset hold, DRDY waits and the lock wait.
    localparam int c_max_a   = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int c_max_cnt = (c_max_a > RST_HOLD_CYCLES) ? c_max_a : RST_HOLD_CYCLES;
    localparam int c_cnt_w   = $clog2(c_max_cnt) + 1;
    localparam logic [c_cnt_w-1:0] c_hold_last = c_cnt_w'(RST_HOLD_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_lock_last = c_cnt_w'(LOCK_TIMEOUT - 1);

    state_t               r_state;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic                 r_pll_rst;
    logic                 r_cfg_ready;
    cfg_entry_t           r_entry;

    logic                  w_txn_start;
    logic                  w_txn_we;
    logic [DRP_ADDR_W-1:0] w_txn_addr;
    logic [DRP_DATA_W-1:0] w_txn_wdata;
    logic [DRP_DATA_W-1:0] w_rd_data;
    logic                  w_txn_ok;
    logic                  w_txn_timeout;

    drp_txn #(
        .DRDY_TIMEOUT (DRDY_TIMEOUT),
        .CNT_W        (c_cnt_w)
    ) u_txn (
        .clk       (DCLK),
        .rst       (RST),
        .i_start   (w_txn_start),
        .i_we      (w_txn_we),
        .i_addr    (w_txn_addr),
        .i_wdata   (w_txn_wdata),
        .i_count   (r_cnt),
        .o_den     (DEN),
        .o_dwe     (DWE),
        .o_daddr   (DADDR),
        .o_di      (DI),
        .i_do      (DO),
        .i_drdy    (DRDY),
        .o_rd_data (w_rd_data),
        .o_ok      (w_txn_ok),
        .o_timeout (w_txn_timeout)
    );

    // Strobes are launched on the same edge that enters READ/WRITE so DEN is
    // high exactly during those states. The write data is merged straight
    // from the DO word presented with DRDY.
    always_comb begin
        w_txn_start = 1'b0;
        w_txn_we    = 1'b0;
        w_txn_addr  = r_entry.addr;
        w_txn_wdata = rmw_merge(w_rd_data, r_entry.mask, r_entry.data);
        case (r_state)
            c_st_fetch: begin
                if (cfg_valid && r_cfg_ready) begin
                    w_txn_start = 1'b1;
                    w_txn_addr  = cfg_addr;
                end
            end
            c_st_wait_rd: begin
                if (w_txn_ok) begin
                    w_txn_start = 1'b1;
                    w_txn_we    = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge DCLK) begin
        if (RST) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_pll_rst   <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_entry     <= '0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= r_cnt + 1'b1;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_busy    <= 1'b1;
                        r_error   <= 1'b0;
                        r_pll_rst <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= c_st_rst_hold;
                    end
                end
                c_st_rst_hold: begin
                    if (r_cnt == c_hold_last) begin
                        r_cfg_ready <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= c_st_fetch;
                    end
                end
                c_st_fetch: begin
                    if (cfg_valid && r_cfg_ready) begin
                        r_entry     <= '{addr: cfg_addr, mask: cfg_mask,
                                         data: cfg_data, last: cfg_last};
                        r_cfg_ready <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= c_st_read;
                    end
                end
                c_st_read: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait_rd;
                end
                c_st_wait_rd: begin
                    if (w_txn_ok) begin
                        r_cnt   <= '0;
                        r_state <= c_st_write;
                    end else if (w_txn_timeout) begin
                        r_error   <= 1'b1;
                        r_pll_rst <= 1'b0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= c_st_idle;
                    end
                end
                c_st_write: begin
                    r_cnt   <= '0;
                    r_state <= c_st_wait_wr;
                end
                c_st_wait_wr: begin
                    if (w_txn_ok) begin
                        r_cnt <= '0;
                        if (r_entry.last) begin
                            r_pll_rst <= 1'b0;
                            r_state   <= c_st_wait_lock;
                        end else begin
                            r_cfg_ready <= 1'b1;
                            r_state     <= c_st_fetch;
                        end
                    end else if (w_txn_timeout) begin
                        r_error   <= 1'b1;
                        r_pll_rst <= 1'b0;
                        r_busy    <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= c_st_idle;
                    end
                end
                c_st_wait_lock: begin
                    if (LOCKED) begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_idle;
                    end else if (r_cnt == c_lock_last) begin
                        r_error <= 1'b1;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign error     = r_error;
    assign PLL_RST   = r_pll_rst;
    assign cfg_ready = r_cfg_ready;

endmodule
`default_nettype wire

// File: tb/tb_pll_drp_reconfig.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_drp_reconfig
// Description : Directed self-checking bench for pll_drp_reconfig. A DRP
//               responder models the PLL register file; expected DRP accesses
//               are queued when entries are offered and compared on each DEN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_pll_drp_reconfig;

    localparam int RST_HOLD = 4;
    localparam int DRDY_TO  = 64;
    localparam int LOCK_TO  = 100;

    logic        DCLK = 1'b0;
    logic        RST, start, cfg_valid, cfg_last, LOCKED;
    logic [6:0]  cfg_addr;
    logic [15:0] cfg_mask, cfg_data, DO;
    logic        rsp_drdy, inj_drdy;
    wire         DRDY = rsp_drdy | inj_drdy;
    logic        busy, done, error, cfg_ready, DEN, DWE, PLL_RST;
    logic [6:0]  DADDR;
    logic [15:0] DI;

    pll_drp_reconfig #(
        .RST_HOLD_CYCLES (RST_HOLD),
        .DRDY_TIMEOUT    (DRDY_TO),
        .LOCK_TIMEOUT    (LOCK_TO)
    ) dut (
        .DCLK (DCLK), .RST (RST), .start (start), .busy (busy), .done (done),
        .error (error), .cfg_valid (cfg_valid), .cfg_ready (cfg_ready),
        .cfg_addr (cfg_addr), .cfg_mask (cfg_mask), .cfg_data (cfg_data),
        .cfg_last (cfg_last), .DADDR (DADDR), .DEN (DEN), .DWE (DWE), .DI (DI),
        .DO (DO), .DRDY (DRDY), .PLL_RST (PLL_RST), .LOCKED (LOCKED)
    );

    initial forever #5 DCLK = ~DCLK;

    typedef struct packed {
        logic        we;
        logic [6:0]  addr;
        logic [15:0] di;
    } txn_t;

    txn_t        exp_q[$];
    logic [15:0] mem [128];
    int n_total = 0, n_pass = 0, n_fail = 0;
    int cyc = 0, den_count = 0, done_count = 0, wr_den_cyc = 0;
    int unexp_den = 0, ready_den_overlap = 0;
    bit drop_rd = 1'b0, drop_wr = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bitwise reference for the read-modify-write result.
    function automatic logic [15:0] bench_merge(input logic [15:0] old_v,
                                                input logic [15:0] m,
                                                input logic [15:0] d);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = m[i] ? old_v[i] : d[i];
        return r;
    endfunction

    initial forever @(posedge DCLK) cyc++;

    // DRP responder and access monitor: DRDY one cycle after DEN.
    initial begin
        bit          pend;
        bit          pdrop;
        logic [15:0] pdo;
        txn_t        e;
        pend = 1'b0; pdrop = 1'b0; pdo = '0;
        rsp_drdy = 1'b0;
        DO = '0;
        forever begin
            @(negedge DCLK);
            rsp_drdy = 1'b0;
            if (pend) begin
                if (!pdrop) begin
                    rsp_drdy = 1'b1;
                    DO = pdo;
                end
                pend = 1'b0;
            end
            if (done) done_count++;
            if (DEN && cfg_ready) ready_den_overlap++;
            if (DEN) begin
                den_count++;
                if (exp_q.size() == 0) begin
                    unexp_den++;
                end else begin
                    e = exp_q.pop_front();
                    check("drp_we", 32'(DWE), 32'(e.we));
                    check("drp_addr", 32'(DADDR), 32'(e.addr));
                    if (e.we) begin
                        check("drp_di", 32'(DI), 32'(e.di));
                        mem[DADDR] = e.di;
                    end
                end
                pend  = 1'b1;
                pdrop = DWE ? drop_wr : drop_rd;
                pdo   = mem[DADDR];
                if (DWE) wr_den_cyc = cyc;
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge DCLK);
        start = 1'b0;
    endtask

    task automatic send_entry(input logic [6:0] a, input logic [15:0] m,
                              input logic [15:0] d, input logic l,
                              input logic [15:0] exp_di, input int gap);
        int n;
        repeat (gap) @(negedge DCLK);
        cfg_addr = a; cfg_mask = m; cfg_data = d; cfg_last = l; cfg_valid = 1'b1;
        exp_q.push_back('{we: 1'b0, addr: a, di: 16'h0});
        exp_q.push_back('{we: 1'b1, addr: a, di: exp_di});
        n = 0;
        while (!cfg_ready && n < 300) begin
            @(negedge DCLK);
            n++;
        end
        check("cfg_ready_seen", 32'(cfg_ready), 32'd1);
        @(negedge DCLK);
        cfg_valid = 1'b0;
        check("read_strobe_den", 32'(DEN), 32'd1);
        check("read_strobe_dwe", 32'(DWE), 32'd0);
        check("ready_low_after_accept", 32'(cfg_ready), 32'd0);
    endtask

    task automatic finish_lock(input int delay);
        int n;
        n = 0;
        while (PLL_RST && n < 300) begin
            @(negedge DCLK);
            n++;
        end
        check("pll_rst_released", 32'(PLL_RST), 32'd0);
        check("pll_rst_fall_after_wr_drdy", 32'(cyc - wr_den_cyc), 32'd2);
        check("busy_in_wait_lock", 32'(busy), 32'd1);
        repeat (delay - 1) @(negedge DCLK);
        LOCKED = 1'b1;
        check("no_done_before_lock", 32'(done), 32'd0);
        @(negedge DCLK);
        check("done_pulse", 32'(done), 32'd1);
        check("busy_cleared", 32'(busy), 32'd0);
        check("error_clear", 32'(error), 32'd0);
        @(negedge DCLK);
        check("done_single_cycle", 32'(done), 32'd0);
        LOCKED = 1'b0;
        @(negedge DCLK);
        check("locked_glitch_busy", 32'(busy), 32'd0);
        check("locked_glitch_done", 32'(done), 32'd0);
    endtask

    initial begin
        int n, c0, base, dbase;
        RST = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_mask = '0;
        cfg_data = '0; cfg_last = 1'b0; LOCKED = 1'b0; inj_drdy = 1'b0;
        for (int i = 0; i < 128; i++) mem[i] = 16'((i * 37) ^ 16'hC3A0);
        repeat (3) @(negedge DCLK);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("rst_den", 32'(DEN), 32'd0);
        check("rst_dwe", 32'(DWE), 32'd0);
        check("rst_pll_rst", 32'(PLL_RST), 32'd0);
        check("rst_daddr", 32'(DADDR), 32'd0);
        check("rst_di", 32'(DI), 32'd0);
        RST = 1'b0;
        @(negedge DCLK);

        // 1: single entry, DO=0x1234 -> DI=0x1041
        mem[8] = 16'h1234;
        pulse_start();
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_pll_rst", 32'(PLL_RST), 32'd1);
        send_entry(7'h08, 16'h1000, 16'h0041, 1'b1, 16'h1041, 0);
        finish_lock(10);

        // 2: three entries with 3-cycle gaps
        base = den_count;
        pulse_start();
        send_entry(7'h08, 16'hF0F0, 16'h0A0A, 1'b0, bench_merge(mem[8], 16'hF0F0, 16'h0A0A), 3);
        check("t2_pll_rst_held_1", 32'(PLL_RST), 32'd1);
        send_entry(7'h09, 16'h00FF, 16'hBE00, 1'b0, bench_merge(mem[9], 16'h00FF, 16'hBE00), 3);
        check("t2_pll_rst_held_2", 32'(PLL_RST), 32'd1);
        send_entry(7'h16, 16'hFFF0, 16'h0005, 1'b1, bench_merge(mem[22], 16'hFFF0, 16'h0005), 3);
        check("t2_pll_rst_held_3", 32'(PLL_RST), 32'd1);
        finish_lock(3);
        check("t2_den_strobes", 32'(den_count - base), 32'd6);

        // 3: mask extremes
        mem[7'h20] = 16'hA5A5;
        mem[7'h21] = 16'h5AF0;
        pulse_start();
        send_entry(7'h20, 16'hFFFF, 16'h1111, 1'b0, 16'hA5A5, 0);
        send_entry(7'h21, 16'h0000, 16'h3C3C, 1'b1, 16'h3C3C, 0);
        finish_lock(2);
        check("t3_queue_drained", 32'(exp_q.size()), 32'd0);

        // 4: write DRDY never returns
        drop_wr = 1'b1;
        dbase = done_count;
        pulse_start();
        send_entry(7'h30, 16'hFF00, 16'h00AA, 1'b1, bench_merge(mem[48], 16'hFF00, 16'h00AA), 0);
        n = 0;
        while (!error && n < 200) begin
            @(negedge DCLK);
            n++;
        end
        check("t4_error", 32'(error), 32'd1);
        check("t4_timeout_cycles", 32'(cyc - wr_den_cyc), 32'd64);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_pll_rst", 32'(PLL_RST), 32'd0);
        check("t4_no_done", 32'(done_count - dbase), 32'd0);
        drop_wr = 1'b0;

        // 5: LOCKED held low; new start clears error
        pulse_start();
        check("t5_error_cleared", 32'(error), 32'd0);
        check("t5_busy", 32'(busy), 32'd1);
        send_entry(7'h31, 16'h0F0F, 16'h1234, 1'b1, bench_merge(mem[49], 16'h0F0F, 16'h1234), 0);
        n = 0;
        while (PLL_RST && n < 300) begin
            @(negedge DCLK);
            n++;
        end
        c0 = cyc;
        n = 0;
        while (!error && n < 300) begin
            @(negedge DCLK);
            n++;
        end
        check("t5_error", 32'(error), 32'd1);
        check("t5_lock_timeout_cycles", 32'(cyc - c0), 32'd100);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_no_done", 32'(done_count - dbase), 32'd0);
        base = den_count;
        repeat (3) begin
            inj_drdy = 1'b1;
            @(negedge DCLK);
            inj_drdy = 1'b0;
            @(negedge DCLK);
        end
        check("t5_idle_drdy_busy", 32'(busy), 32'd0);
        check("t5_idle_drdy_error_sticky", 32'(error), 32'd1);
        check("t5_idle_drdy_no_den", 32'(den_count - base), 32'd0);
        check("t5_idle_drdy_ready", 32'(cfg_ready), 32'd0);

        // 6: start while busy ignored; reset during WAIT_RD
        pulse_start();
        @(negedge DCLK);
        pulse_start();
        check("t6_busy", 32'(busy), 32'd1);
        check("t6_error", 32'(error), 32'd0);
        drop_rd = 1'b1;
        send_entry(7'h40, 16'h0000, 16'h7777, 1'b0, 16'h7777, 0);
        @(negedge DCLK);
        RST = 1'b1;
        @(negedge DCLK);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_den", 32'(DEN), 32'd0);
        check("t6_rst_dwe", 32'(DWE), 32'd0);
        check("t6_rst_pll_rst", 32'(PLL_RST), 32'd0);
        check("t6_rst_cfg_ready", 32'(cfg_ready), 32'd0);
        check("t6_rst_daddr", 32'(DADDR), 32'd0);
        check("t6_rst_di", 32'(DI), 32'd0);
        RST = 1'b0;
        exp_q.delete();
        drop_rd = 1'b0;
        base = den_count;
        @(negedge DCLK);
        inj_drdy = 1'b1;
        @(negedge DCLK);
        inj_drdy = 1'b0;
        repeat (5) @(negedge DCLK);
        check("t6_late_drdy_no_den", 32'(den_count - base), 32'd0);
        check("t6_late_drdy_busy", 32'(busy), 32'd0);

        check("unexpected_den_count", 32'(unexp_den), 32'd0);
        check("cfg_ready_with_den", 32'(ready_den_overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
